// File: rtl/crt_timing_gen_if.sv
// Video timing bus between crt_timing_gen (master) and the pixel/colour logic (slave).
// FrameCount exists only when CRT_FRAME_COUNT_EN is defined.
interface crt_timing_gen_if #(
  parameter int RES_W = 10
`ifdef CRT_FRAME_COUNT_EN
  , parameter int FRAME_W = 8
`endif
);

  logic             Enable;
  logic             PixelTick;
  logic             hsync;
  logic             vsync;
  logic             ActiveVideo;
  logic [RES_W-1:0] xpos;
  logic [RES_W-1:0] ypos;
  logic             LineEnd;
  logic             FrameStart;
`ifdef CRT_FRAME_COUNT_EN
  logic [FRAME_W-1:0] FrameCount;
`endif

  modport master (
    input  Enable,
    output PixelTick, hsync, vsync, ActiveVideo, xpos, ypos, LineEnd, FrameStart
`ifdef CRT_FRAME_COUNT_EN
    , output FrameCount
`endif
  );

  modport slave (
    output Enable,
    input  PixelTick, hsync, vsync, ActiveVideo, xpos, ypos, LineEnd, FrameStart
`ifdef CRT_FRAME_COUNT_EN
    , input FrameCount
`endif
  );

endinterface

// File: rtl/crt_timing_gen.sv
// Parametrised VGA/CRT timing generator with pixel-tick divider and line/frame strobes.
// Optional frame counter output enabled by defining CRT_FRAME_COUNT_EN.
module crt_timing_gen #(
  parameter int RES_W     = 10,
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CLK_DIV   = 4,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int FRAME_W   = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  crt_timing_gen_if.master crt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [RES_W-1:0] H_LAST     = RES_W'(H_TOTAL - 1);
  localparam logic [RES_W-1:0] V_LAST     = RES_W'(V_TOTAL - 1);
  localparam logic [RES_W-1:0] H_ACT_END  = RES_W'(H_ACTIVE);
  localparam logic [RES_W-1:0] V_ACT_END  = RES_W'(V_ACTIVE);
  localparam logic [RES_W-1:0] H_SYNC_BEG = RES_W'(H_ACTIVE + H_FP);
  localparam logic [RES_W-1:0] H_SYNC_END = RES_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [RES_W-1:0] V_SYNC_BEG = RES_W'(V_ACTIVE + V_FP);
  localparam logic [RES_W-1:0] V_SYNC_END = RES_W'(V_ACTIVE + V_FP + V_SYNC);

  // Parameter sanity checks, reported at elaboration.
  if (CLK_DIV < 1) begin : g_bad_div
    $error("crt_timing_gen: CLK_DIV must be >= 1");
  end
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : g_bad_h
    $error("crt_timing_gen: horizontal active/porch/sync widths must be >= 1");
  end
  if (V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_v
    $error("crt_timing_gen: vertical active/porch/sync widths must be >= 1");
  end
  if (H_TOTAL >= (1 << RES_W) || V_TOTAL >= (1 << RES_W)) begin : g_bad_total
    $error("crt_timing_gen: H_TOTAL and V_TOTAL must be < 2**RES_W");
  end
  if (FRAME_W < 1) begin : g_bad_frame
    $error("crt_timing_gen: FRAME_W must be >= 1");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic [RES_W-1:0] h_q, h_d;
  logic [RES_W-1:0] v_q, v_d;
  logic             tick;

  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             av_q, av_d;
  logic             fs_q, fs_d;
  logic [RES_W-1:0] x_q, x_d;
  logic [RES_W-1:0] y_q, y_d;
  logic             h_vis, v_vis;

  // Registered outputs are decoded from the next counts so they describe
  // the counters they are loaded alongside, with no added latency.
  always_comb begin
    tick  = crt.Enable && (div_q == DIV_LAST);
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;

    if (crt.Enable) begin
      div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    if (tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + RES_W'(1);
      end else begin
        h_d = h_q + RES_W'(1);
      end
    end

    h_vis = (h_d < H_ACT_END);
    v_vis = (v_d < V_ACT_END);
    av_d  = h_vis && v_vis;
    x_d   = av_d ? h_d : '0;
    y_d   = av_d ? v_d : '0;
    hs_d  = ((h_d >= H_SYNC_BEG) && (h_d < H_SYNC_END)) ? HSYNC_POL : ~HSYNC_POL;
    vs_d  = ((v_d >= V_SYNC_BEG) && (v_d < V_SYNC_END)) ? VSYNC_POL : ~VSYNC_POL;
    fs_d  = tick && (h_d == '0) && (v_d == '0);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      div_q <= '0;
      h_q   <= H_LAST;
      v_q   <= V_LAST;
      hs_q  <= ~HSYNC_POL;
      vs_q  <= ~VSYNC_POL;
      av_q  <= 1'b0;
      x_q   <= '0;
      y_q   <= '0;
      fs_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      av_q  <= av_d;
      x_q   <= x_d;
      y_q   <= y_d;
      fs_q  <= fs_d;
    end
  end

  assign crt.PixelTick   = tick;
  assign crt.LineEnd     = tick && (h_q == H_LAST);
  assign crt.hsync       = hs_q;
  assign crt.vsync       = vs_q;
  assign crt.ActiveVideo = av_q;
  assign crt.xpos        = x_q;
  assign crt.ypos        = y_q;
  assign crt.FrameStart  = fs_q;

`ifdef CRT_FRAME_COUNT_EN
  logic [FRAME_W-1:0] fc_q;

  // Counts on the edge that raises FrameStart, so frame 1 reads 1 throughout.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      fc_q <= '0;
    end else if (fs_d) begin
      fc_q <= fc_q + FRAME_W'(1);
    end
  end

  assign crt.FrameCount = fc_q;
`endif

endmodule

// File: tb/tb_crt_timing_gen.sv
// Directed bench for crt_timing_gen: small 12x10 raster, CLK_DIV=2, both hsync polarities.
module tb_crt_timing_gen;

  logic Clock = 1'b0;
  logic Reset;
  int   tests = 0;
  int   fails = 0;

  always #5 Clock = ~Clock;

  crt_timing_gen_if #(
    .RES_W(4)
`ifdef CRT_FRAME_COUNT_EN
    , .FRAME_W(2)
`endif
  ) bus0 ();

  crt_timing_gen_if #(
    .RES_W(4)
`ifdef CRT_FRAME_COUNT_EN
    , .FRAME_W(2)
`endif
  ) bus1 ();

  crt_timing_gen #(
    .RES_W(4), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(2), .V_SYNC(1), .V_BP(3),
    .CLK_DIV(2), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .FRAME_W(2)
  ) dut0 (
    .Clock(Clock),
    .Reset(Reset),
    .crt  (bus0.master)
  );

  crt_timing_gen #(
    .RES_W(4), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(2), .V_SYNC(1), .V_BP(3),
    .CLK_DIV(2), .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .FRAME_W(2)
  ) dut1 (
    .Clock(Clock),
    .Reset(Reset),
    .crt  (bus1.master)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_vid(input string tag, input int hs, input int vs, input int av,
                         input int x, input int y);
    chk({tag, "_hsync"}, 32'(bus0.hsync), hs);
    chk({tag, "_vsync"}, 32'(bus0.vsync), vs);
    chk({tag, "_active"}, 32'(bus0.ActiveVideo), av);
    chk({tag, "_xpos"}, 32'(bus0.xpos), x);
    chk({tag, "_ypos"}, 32'(bus0.ypos), y);
  endtask

  initial begin
    int h;
    int hs_low;
    int vs_low;
    int vs_first;
    int fs_cnt;
    int av_cnt;

    Reset       = 1'b1;
    bus0.Enable = 1'b1;
    bus1.Enable = 1'b1;
    repeat (3) @(negedge Clock);

    // Reset state (Reset wins over Enable=1)
    chk_vid("rst", 1, 1, 0, 0, 0);
    chk("rst_tick", 32'(bus0.PixelTick), 0);
    chk("rst_lineend", 32'(bus0.LineEnd), 0);
    chk("rst_framestart", 32'(bus0.FrameStart), 0);
    chk("rst_hsync_pol1", 32'(bus1.hsync), 0);
`ifdef CRT_FRAME_COUNT_EN
    chk("rst_framecount", 32'(bus0.FrameCount), 0);
`endif

    // First tick after release enters (0,0); the parked last pixel produces a LineEnd
    Reset = 1'b0;
    @(negedge Clock);
    chk("t1_tick", 32'(bus0.PixelTick), 1);
    chk("t1_lineend", 32'(bus0.LineEnd), 1);
    chk("t1_fs_early", 32'(bus0.FrameStart), 0);
    @(negedge Clock);
    chk("t1_framestart", 32'(bus0.FrameStart), 1);
    chk("t1_tick_low", 32'(bus0.PixelTick), 0);
    chk_vid("t1_px00", 1, 1, 1, 0, 0);
`ifdef CRT_FRAME_COUNT_EN
    chk("t1_framecount", 32'(bus0.FrameCount), 1);
`endif

    // Line 0: two clocks per pixel, hsync region 9..10, blanking 8..11
    hs_low = 0;
    for (int k = 0; k < 24; k++) begin
      h = k / 2;
      chk($sformatf("l0_tick_k%0d", k), 32'(bus0.PixelTick), k % 2);
      chk($sformatf("l0_hsync_k%0d", k), 32'(bus0.hsync), (h == 9 || h == 10) ? 0 : 1);
      chk($sformatf("l0_hsync_pol1_k%0d", k), 32'(bus1.hsync), (h == 9 || h == 10) ? 1 : 0);
      chk($sformatf("l0_active_k%0d", k), 32'(bus0.ActiveVideo), (h < 8) ? 1 : 0);
      chk($sformatf("l0_xpos_k%0d", k), 32'(bus0.xpos), (h < 8) ? h : 0);
      chk($sformatf("l0_lineend_k%0d", k), 32'(bus0.LineEnd), (k == 23) ? 1 : 0);
      chk($sformatf("l0_framestart_k%0d", k), 32'(bus0.FrameStart), (k == 0) ? 1 : 0);
      if (bus0.hsync === 1'b0) hs_low++;
      @(negedge Clock);
    end
    chk("l0_hsync_low_clocks", hs_low, 4);

    // Remaining lines 1..9 of the frame
    vs_low   = 0;
    vs_first = -1;
    fs_cnt   = 0;
    av_cnt   = 0;
    for (int k = 24; k < 240; k++) begin
      if (bus0.vsync === 1'b0) begin
        vs_low++;
        if (vs_first < 0) vs_first = k;
      end
      if (bus0.FrameStart !== 1'b0) fs_cnt++;
      if (bus0.ActiveVideo === 1'b1) av_cnt++;
      if (k == 24 * 3 + 2 * 5) chk_vid("l3_px5", 1, 1, 1, 5, 3);
      if (k == 24 * 4 + 2 * 2) chk_vid("l4_px2", 1, 1, 0, 0, 0);
      @(negedge Clock);
    end
    chk("frame_vsync_low_clocks", vs_low, 24);
    chk("frame_vsync_first_clock", vs_first, 144);
    chk("frame_no_extra_framestart", fs_cnt, 0);
    chk("frame_active_clocks_l1to9", av_cnt, 48);

    // 240 clocks after the first, the second frame starts
    chk("f2_framestart", 32'(bus0.FrameStart), 1);
    chk_vid("f2_px00", 1, 1, 1, 0, 0);
`ifdef CRT_FRAME_COUNT_EN
    chk("f2_framecount", 32'(bus0.FrameCount), 2);
`endif

    // Freeze at xpos=3
    repeat (6) @(negedge Clock);
    chk("en_pre_xpos", 32'(bus0.xpos), 3);
    bus0.Enable = 1'b0;
    bus1.Enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      chk($sformatf("en_off_xpos_%0d", i), 32'(bus0.xpos), 3);
      chk($sformatf("en_off_tick_%0d", i), 32'(bus0.PixelTick), 0);
      chk($sformatf("en_off_active_%0d", i), 32'(bus0.ActiveVideo), 1);
    end
    bus0.Enable = 1'b1;
    bus1.Enable = 1'b1;
    @(negedge Clock);
    chk("en_on1_xpos", 32'(bus0.xpos), 3);
    chk("en_on1_tick", 32'(bus0.PixelTick), 1);
    @(negedge Clock);
    chk("en_on2_xpos", 32'(bus0.xpos), 4);
    chk("en_on2_tick", 32'(bus0.PixelTick), 0);

    // Advance to (5,2), then reset mid-frame
    repeat (50) @(negedge Clock);
    chk_vid("pre_rst_px52", 1, 1, 1, 5, 2);
    Reset = 1'b1;
    @(negedge Clock);
    chk_vid("mid_rst", 1, 1, 0, 0, 0);
    chk("mid_rst_tick", 32'(bus0.PixelTick), 0);
    chk("mid_rst_framestart", 32'(bus0.FrameStart), 0);
    chk("mid_rst_hsync_pol1", 32'(bus1.hsync), 0);
`ifdef CRT_FRAME_COUNT_EN
    chk("mid_rst_framecount", 32'(bus0.FrameCount), 0);
`endif
    Reset = 1'b0;
    @(negedge Clock);
    chk("post_rst_tick", 32'(bus0.PixelTick), 1);
    chk("post_rst_fs_early", 32'(bus0.FrameStart), 0);
    @(negedge Clock);
    chk("post_rst_framestart", 32'(bus0.FrameStart), 1);
    chk_vid("post_rst_px00", 1, 1, 1, 0, 0);
`ifdef CRT_FRAME_COUNT_EN
    chk("post_rst_framecount", 32'(bus0.FrameCount), 1);
`endif

    // Frames 2..4 after reset; a 2-bit frame counter wraps to 0 on frame 4
    for (int f = 2; f <= 4; f++) begin
      repeat (240) @(negedge Clock);
      chk($sformatf("frame%0d_framestart", f), 32'(bus0.FrameStart), 1);
`ifdef CRT_FRAME_COUNT_EN
      chk($sformatf("frame%0d_framecount", f), 32'(bus0.FrameCount), f % 4);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
